// File: rtl/fsqrt_pkg.sv
// Shared types and helpers for the iterative square-root unit.
// Holds the FSM state enum, the operand class enum and the format constant helpers.
package fsqrt_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ROUND, DONE} state_t;

  typedef enum logic [2:0] {NORMAL, ZERO, SUBN, INF, QNAN, SNAN, NEG} cls_t;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits.
  function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 32'd1));
    return v;
  endfunction

endpackage

// File: rtl/fsqrt_if.sv
// Operand/result handshake bundle for fsqrt_iter.
// The producer/consumer side is the master; the root unit is the slave.
interface fsqrt_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         invalid;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, y, invalid
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, y, invalid
  );
endinterface

// File: rtl/fsqrt_classify.sv
// Combinational operand decoder: splits x into a special class and its sign.
// Subnormals are classified before the sign test so they flush to a signed zero.
module fsqrt_classify
  import fsqrt_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_x,
  output cls_t                 o_cls,
  output logic                 o_sign
);
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;

  assign o_sign = i_x[EXP_W+MAN_W];
  assign w_exp  = i_x[EXP_W+MAN_W-1:MAN_W];
  assign w_frac = i_x[MAN_W-1:0];

  always_comb begin
    o_cls = NORMAL;
    if (w_exp == '1) begin
      if (w_frac == '0)            o_cls = o_sign ? NEG : INF;
      else if (w_frac[MAN_W-1])    o_cls = QNAN;
      else                         o_cls = SNAN;
    end else if (w_exp == '0) begin
      o_cls = (w_frac == '0) ? ZERO : SUBN;
    end else if (o_sign) begin
      o_cls = NEG;
    end
  end
endmodule

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-style square root: one restoring-recurrence root bit per cycle,
// then a single round-to-nearest-even step. Special operands bypass the recurrence.
module fsqrt_iter
  import fsqrt_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic    clk,
  input logic    rst,
  fsqrt_if.slave bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned ITER = MAN_W + 2;
  localparam int unsigned CW   = $clog2(ITER);
  localparam int unsigned BIAS = bias(EXP_W);
  localparam logic [W-1:0] QNAN_W = W'(qnan(EXP_W, MAN_W));

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_x, r_y;
  logic            r_inv;
  logic [ITER-1:0] r_q;
  logic [ITER:0]   r_rem;

  cls_t w_cls;
  logic w_sign;

  fsqrt_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .i_x    (bus.x),
    .o_cls  (w_cls),
    .o_sign (w_sign)
  );

  logic [W-1:0] w_spec_y;
  logic         w_spec_inv;

  always_comb begin
    w_spec_y   = QNAN_W;
    w_spec_inv = 1'b0;
    case (w_cls)
      ZERO, INF: w_spec_y = bus.x;
      SUBN:      w_spec_y = {w_sign, {(W-1){1'b0}}};
      SNAN, NEG: w_spec_inv = 1'b1;
      default:   ;
    endcase
  end

  // Radicand is rebuilt from the registered operand; pairs are fed MSB-first by r_cnt.
  logic [EXP_W-1:0]        w_e;
  logic signed [EXP_W:0]   w_eu, w_half;
  logic [ITER-1:0]         w_rad;
  logic [CW:0]             w_sh;
  logic [1:0]              w_pair;
  logic [ITER+2:0]         w_rem_sh, w_trial;
  logic                    w_ge;
  logic [ITER:0]           w_rem_nxt;

  assign w_e       = r_x[W-2:MAN_W];
  assign w_eu      = signed'({1'b0, w_e}) - signed'((EXP_W+1)'(BIAS));
  assign w_half    = w_eu >>> 1;
  assign w_rad     = w_eu[0] ? {1'b1, r_x[MAN_W-1:0], 1'b0} : {2'b01, r_x[MAN_W-1:0]};
  assign w_sh      = (CW+1)'(2 * ITER - 2) - {r_cnt, 1'b0};
  assign w_pair    = 2'({w_rad, {ITER{1'b0}}} >> w_sh);
  assign w_rem_sh  = {r_rem, w_pair};
  assign w_trial   = {1'b0, r_q, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nxt = w_ge ? (ITER+1)'(w_rem_sh - w_trial) : w_rem_sh[ITER:0];

  logic                 w_up, w_carry;
  logic [MAN_W+1:0]     w_mant;
  logic [MAN_W-1:0]     w_frac;
  logic [EXP_W-1:0]     w_rexp;

  // r_q[0] is the guard bit; any nonzero remainder is the sticky bit.
  assign w_up    = r_q[0] & ((|r_rem) | r_q[1]);
  assign w_mant  = {1'b0, r_q[ITER-1:1]} + (MAN_W+2)'(w_up);
  assign w_carry = w_mant[MAN_W+1];
  assign w_frac  = w_carry ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
  assign w_rexp  = EXP_W'(w_half) + EXP_W'(BIAS) + EXP_W'(w_carry);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = (w_cls == NORMAL) ? BUSY : DONE;
      BUSY:    if (r_cnt == CW'(ITER - 1)) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_inv <= 1'b0;
      r_q   <= '0;
      r_rem <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_x   <= bus.x;
          r_cnt <= '0;
          r_q   <= '0;
          r_rem <= '0;
          if (w_cls != NORMAL) begin
            r_y   <= w_spec_y;
            r_inv <= w_spec_inv;
          end
        end
        BUSY: begin
          r_q   <= {r_q[ITER-2:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        ROUND: begin
          r_y   <= {r_x[W-1], w_rexp, w_frac};
          r_inv <= 1'b0;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.y         = r_y;
  assign bus.invalid   = r_inv;
endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter at default parameters: directed, random,
// backpressure and mid-operation reset, against an integer-sqrt reference model.
module tb_fsqrt_iter;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  fsqrt_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fsqrt_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic bit is_normal(input logic [31:0] a);
    return !a[31] && a[30:23] != 8'd0 && a[30:23] != 8'hFF;
  endfunction

  // Reference: {invalid, y}. Exact integer sqrt, then nearest rounding by remainder.
  function automatic logic [32:0] ref_sqrt(input logic [31:0] a);
    logic [7:0]      e;
    logic [22:0]     f;
    int              eu, re;
    longint unsigned m, n, q, t;
    e = a[30:23];
    f = a[22:0];
    if (e == 8'hFF && f != 0) return {~f[22], 32'h7FC00000};
    if (e == 8'd0)            return {1'b0, a[31], 31'd0};
    if (a[31])                return {1'b1, 32'h7FC00000};
    if (e == 8'hFF)           return {1'b0, 32'h7F800000};
    eu = int'(e) - 127;
    m  = 64'h800000 | 64'(f);
    if (eu % 2 != 0) begin
      m  = m << 1;
      eu = eu - 1;
    end
    n = m << 23;
    q = 0;
    for (int b = 24; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= n) q = t;
    end
    if (n - q * q > q) q = q + 1;
    re = eu / 2 + 127;
    if (q == (64'd1 << 24)) begin
      q  = 64'd1 << 23;
      re = re + 1;
    end
    return {1'b0, 1'b0, 8'(re), 23'(q)};
  endfunction

  task automatic issue(input logic [31:0] v);
    check("acc_rdy", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.x        = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Entered at the negedge right after the accept edge (cycle 1).
  task automatic wait_result(input logic [31:0] a, input int hold);
    logic [32:0] r;
    int          lat;
    r   = ref_sqrt(a);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check($sformatf("timeout_%h", a), 0, 1);
    end else begin
      check($sformatf("lat_%h", a), lat, is_normal(a) ? 27 : 1);
      check($sformatf("y_%h", a), bus.y, r[31:0]);
      check($sformatf("inv_%h", a), bus.invalid, r[32]);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_y", bus.y, r[31:0]);
        check("hold_rdy", bus.in_ready, 0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_rdy", bus.in_ready, 1);
  endtask

  task automatic run(input logic [31:0] a, input int hold);
    issue(a);
    wait_result(a, hold);
  endtask

  logic [31:0] dir [12] = '{32'h40400000, 32'h40800000, 32'h437F0000, 32'h40000000,
                            32'h00000000, 32'h80000000, 32'h7F800000, 32'hBF800000,
                            32'h7F800001, 32'h00000001, 32'h3F000000, 32'hFFC00000};

  initial begin
    int          seen;
    logic [31:0] v;
    clk           = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x         = 32'h3F800000;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy", bus.in_ready, 1);
    check("rst_ov", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    check("rst_inv", bus.invalid, 0);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    foreach (dir[i]) run(dir[i], 0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      if (i % 4 != 0) begin
        v[31]    = 1'b0;
        v[30:23] = 8'($urandom_range(1, 254));
      end
      run(v, $urandom_range(0, 2));
    end

    // Backpressure with a second operand waiting on in_valid.
    issue(32'h40400000);
    bus.in_valid = 1'b1;
    bus.x        = 32'h40800000;
    wait_result(32'h40400000, 10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_busy", bus.in_ready, 0);
    wait_result(32'h40800000, 0);

    // Reset in cycle 10 of an operation.
    issue(32'h40400000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rdy", bus.in_ready, 1);
    check("mid_ov", bus.out_valid, 0);
    check("mid_y", bus.y, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_noval", seen, 0);
    run(32'h40800000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fsqrt_iter.md
FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: fraction field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operand x present.
REQ-006 in_ready  out  1  unit accepts operand this cycle.
REQ-007 x  in  W  IEEE-style operand {sign, exp, frac}.
REQ-008 out_valid  out  1  result y/invalid present.
REQ-009 out_ready  in  1  consumer takes result this cycle.
REQ-010 y  out  W  square root of x, round-to-nearest-even.
REQ-011 invalid  out  1  IEEE invalid-operation flag for this result.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 Accept occurs when in_valid && in_ready; x is registered, and IDLE -> BUSY (normal operand) or IDLE -> DONE (special operand).
REQ-014 SHALL hold one operation in flight at a time; in_valid is ignored outside IDLE.
REQ-015 Special classes SHALL be resolved without iteration:
- NaN -> canonical qNaN {0, all-ones, 1, 0...}; invalid = 1 only for sNaN.
- Negative nonzero, including -inf -> canonical qNaN, invalid = 1.
- +/-0 -> same signed zero.
- Subnormal -> flushed to a zero of the same sign, invalid = 0.
- +inf -> +inf.
REQ-016 Normal operand, unbiased exponent E = e - BIAS, where BIAS = 2^(EXP_W-1)-1.
- Radicand = 1.frac, left-shifted 1 when E is odd.
- Result exponent = floor(E/2) + BIAS (arithmetic shift).
REQ-017 BUSY SHALL run restoring digit recurrence producing one root bit per cycle for ITER = MAN_W+2 cycles (MAN_W+1 root bits plus 1 guard bit), using an iteration counter.
REQ-018 ROUND (1 cycle):
- sticky = (remainder != 0).
- Round to nearest-even on the guard and sticky bits.
- A carry out of the root SHALL increment the exponent.
REQ-019 Latency from the accept edge to out_valid: ITER+2 cycles for normal operands (27 at default parameters); 1 cycle for special operands.
REQ-020 In DONE, y and invalid SHALL be stable until out_ready; DONE && out_ready -> IDLE, so in_ready is high the following cycle.
REQ-021 out_ready SHALL be ignored outside DONE; invalid SHALL be 0 for every non-special result.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE, out_valid = 0, in_ready = 1, y = 0, invalid = 0, and iteration counter = 0.
REQ-023 rst mid-operation SHALL discard the operation with no result emitted; rst has priority over every accept or handshake in the same cycle.

Structure
REQ-024 Shared package fsqrt_pkg SHALL hold the FSM state enum, the special-class enum (NORMAL, ZERO, SUBN, INF, QNAN, SNAN, NEG), and functions bias(EXP_W) and qnan(EXP_W, MAN_W).
REQ-025 A combinational sub-module fsqrt_classify SHALL decode x into class and sign; recurrence, rounding and FSM stay in fsqrt_iter.

Verification (defaults; latency per REQ-019)
REQ-026 x = 0x40400000 (3.0) -> y = 0x3FDDB3D7, invalid = 0, out_valid exactly 27 cycles after accept; x = 0x40800000 (4.0) -> 0x40000000.
REQ-027 x = 0x437F0000 (255) -> 0x417F7FE0; x = 0x40000000 (2.0) -> 0x3FB504F3 (odd-exponent path).
REQ-028 Specials, each 1 cycle after accept:
- 0x00000000 -> 0x00000000 and 0x80000000 -> 0x80000000.
- 0x7F800000 -> 0x7F800000.
- 0xBF800000 -> 0x7FC00000 with invalid = 1.
- 0x7F800001 -> 0x7FC00000 with invalid = 1.
- 0x00000001 -> 0x00000000 with invalid = 0.
REQ-029 Backpressure: hold out_ready = 0 for 10 cycles with in_valid held high:
- y stays stable and in_ready stays 0.
- No second accept occurs until the cycle after out_ready = 1.
REQ-030 Assert rst at cycle 10 of a 3.0 operation:
- No out_valid is emitted.
- in_ready = 1 on the next cycle.
- A following 4.0 operation returns 0x40000000 with correct latency.
